// File: rtl/decoder_scan_ctrl_if.sv
// Control and decoder-drive bundle between a sequencer master and the scan controller.
// The slave modport is the scan controller's view.
interface decoder_scan_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [DIV_W-1:0] div;
    logic [1:0]       A;
    logic             E;
    logic             busy;
    logic             sweep_done;

    modport master (
        output start, stop, mode, div,
        input  A, E, busy, sweep_done
    );

    modport slave (
        input  start, stop, mode, div,
        output A, E, busy, sweep_done
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Address/enable scanner for a downstream 2:4 decoder: steps A through 0..3 with a
// programmable dwell and an E-low blanking gap between addresses.
module decoder_scan_ctrl #(
    parameter int DIV_W = 8,
    parameter int BLANK = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_scan_ctrl_if.slave   bus
);

    localparam bit       HAS_BLANK = (BLANK > 0);
    localparam int       BLANK_M1  = (BLANK > 0) ? BLANK - 1 : 0;
    localparam logic [3:0] BCNT_INIT = 4'(BLANK_M1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [1:0]         a_q, a_n;
    logic               e_q, e_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [DIV_W-1:0]   dcnt_q, dcnt_n;
    logic [3:0]         bcnt_q, bcnt_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic               adv;

    // State register: all outputs come straight from flops so A/E never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 2'b00;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            e_q     <= e_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            dcnt_q  <= dcnt_n;
            bcnt_q  <= bcnt_n;
        end
    end

    // Captured dwell length is pure data; it is only consumed while busy.
    always_ff @(posedge clk) begin
        div_q <= div_n;
    end

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        e_n     = e_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        dcnt_n  = dcnt_q;
        bcnt_n  = bcnt_q;
        div_n   = div_q;
        adv     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_n = S_DWELL;
                    a_n     = 2'b00;
                    e_n     = 1'b1;
                    busy_n  = 1'b1;
                    div_n   = bus.div;
                    dcnt_n  = bus.div;
                end
            end
            S_DWELL: begin
                if (dcnt_q == '0) begin
                    if (HAS_BLANK) begin
                        state_n = S_BLANK;
                        e_n     = 1'b0;
                        bcnt_n  = BCNT_INIT;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    dcnt_n = dcnt_q - 1'b1;
                end
            end
            S_BLANK: begin
                if (bcnt_q == 4'd0) adv = 1'b1;
                else                bcnt_n = bcnt_q - 4'd1;
            end
            default: state_n = S_IDLE;
        endcase

        // Mode is sampled only here, so a mid-sweep change lands at the sweep boundary.
        if (adv) begin
            if (a_q != 2'd3) begin
                state_n = S_DWELL;
                a_n     = a_q + 2'd1;
                e_n     = 1'b1;
                dcnt_n  = div_q;
            end else begin
                done_n = 1'b1;
                a_n    = 2'b00;
                if (!bus.mode) begin
                    state_n = S_DWELL;
                    e_n     = 1'b1;
                    dcnt_n  = div_q;
                end else begin
                    state_n = S_IDLE;
                    e_n     = 1'b0;
                    busy_n  = 1'b0;
                end
            end
        end

        // An abort overrides everything, including a sweep-end pulse on the same edge.
        if (bus.stop && (state_q != S_IDLE)) begin
            state_n = S_IDLE;
            a_n     = 2'b00;
            e_n     = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_comb begin
        bus.A          = a_q;
        bus.E          = e_q;
        bus.busy       = busy_q;
        bus.sweep_done = done_q;
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: directed scenarios plus random start/stop/mode/div traffic,
// checked every cycle against a timeline model of the scan sequence.
module tb_decoder_scan_ctrl;

    localparam int DIV_W = 8;
    localparam int BLANK = 2;

    logic clk;
    logic rst;

    decoder_scan_ctrl_if #(.DIV_W(DIV_W)) bus ();

    decoder_scan_ctrl #(.DIV_W(DIV_W), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: t counts cycles since the accepted start; everything follows from t and div_q.
    bit m_act;
    int m_t;
    int m_divq;
    bit m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_t    <= 0;
            m_divq <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_act) begin
                if (bus.stop) begin
                    m_act <= 1'b0;
                end else if (((m_t + 1) % (4 * (m_divq + 1 + BLANK)) == 0) && bus.mode) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (bus.start && !bus.stop) begin
                m_act  <= 1'b1;
                m_t    <= 0;
                m_divq <= int'(bus.div);
            end
        end
    end

    bit chk_en;

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            int per, r, ea, ee, eb, ed, d_obs, d_exp;
            per = m_divq + 1 + BLANK;
            if (m_act) begin
                r  = m_t % (4 * per);
                ea = r / per;
                ee = ((r % per) <= m_divq) ? 1 : 0;
                eb = 1;
                ed = (m_t > 0 && r == 0) ? 1 : 0;
            end else begin
                ea = 0; ee = 0; eb = 0;
                ed = m_done ? 1 : 0;
            end
            chk("A", int'(bus.A), ea);
            chk("E", int'(bus.E), ee);
            chk("busy", int'(bus.busy), eb);
            chk("sweep_done", int'(bus.sweep_done), ed);
            d_obs = bus.E ? (1 << bus.A) : 0;
            d_exp = ee ? (1 << ea) : 0;
            chk("decoder_D", d_obs, d_exp);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int d, input bit md);
        bus.div   = DIV_W'(d);
        bus.mode  = md;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.div   = '0;
        cyc(3);
        chk("rst_A", int'(bus.A), 0);
        chk("rst_E", int'(bus.E), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.sweep_done), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(2);

        // Single sweep, div=1
        pulse_start(1, 1'b1);
        cyc(22);

        // Continuous, div=0, three sweeps then stop during address 2 dwell
        pulse_start(0, 1'b0);
        cyc(36);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (bus.A == 2'd2 && bus.E) found = 1'b1;
                else cyc(1);
            end
            chk("stop_wait", int'(found), 1);
            bus.stop = 1'b1;
            cyc(1);
            bus.stop = 1'b0;
        end
        cyc(4);

        // Start and stop together from IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cyc(3);

        // Start pulses while busy and div changed mid-sweep; the next start picks up div=5
        pulse_start(1, 1'b1);
        for (int i = 0; i < 18; i++) begin
            bus.start = (i % 3 == 0);
            if (i == 5) bus.div = DIV_W'(5);
            cyc(1);
        end
        bus.start = 1'b0;
        cyc(3);
        pulse_start(5, 1'b1);
        cyc(36);

        // Asynchronous reset in the middle of a dwell
        pulse_start(3, 1'b0);
        cyc(1);
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_A", int'(bus.A), 0);
        chk("async_rst_E", int'(bus.E), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.start = ($urandom_range(0, 9) == 0);
            bus.stop  = ($urandom_range(0, 39) == 0);
            bus.mode  = ($urandom_range(0, 3) == 0);
            bus.div   = DIV_W'($urandom_range(0, 3));
            cyc(1);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
